// File: rtl/display_board_ram_pkg.sv
// Shared definitions for the display board store.
//   - Board geometry: 8x8 cells, 2 bits per cell, 6-bit cell address {row, col}.
//   - Cell encoding: bit SIDE_RED lights the red LED, bit SIDE_GREEN the green one.
//     The value 11 is legal and counts toward both colours.
//   - Control FSM state type.
package display_board_ram_pkg;

   localparam int CELLS  = 64;
   localparam int ADDR_W = 6;
   localparam int CELL_W = 2;
   localparam int CNT_W  = 7;   // holds 0..64

   localparam int SIDE_RED   = 1;
   localparam int SIDE_GREEN = 0;

   localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
   localparam logic [CELL_W-1:0] CELL_RED   = 2'b10;
   localparam logic [CELL_W-1:0] CELL_GREEN = 2'b01;

   localparam logic [ADDR_W-1:0] LAST_CELL = 6'd63;

   typedef logic [ADDR_W-1:0] cell_addr_t;
   typedef logic [CELL_W-1:0] cell_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/display_board_ram_board_cell_array.sv
// board_cell_array: 64 x 2-bit register array.
//   clk, rst_n   : clock, asynchronous active-low reset (clears every cell to 00)
//   we, waddr,
//   wdata        : single synchronous write port
//   old_data     : combinational read at waddr (prior contents of the cell being written)
//   rd_addr,
//   rd_data      : combinational read port for the LED scanner
module board_cell_array
   import display_board_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we,
   input  cell_addr_t waddr,
   input  cell_t      wdata,
   output cell_t      old_data,
   input  cell_addr_t rd_addr,
   output cell_t      rd_data
);

   cell_t cells [CELLS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CELLS; i++) begin
            cells[i] <= CELL_EMPTY;
         end
      end else if (we) begin
         cells[waddr] <= wdata;
      end
   end

   assign rd_data  = cells[rd_addr];
   assign old_data = cells[waddr];

endmodule

// File: rtl/display_board_ram.sv
// display_board_ram: board store between the game controller and the LED scanner.
//   clk, rst_n              : clock, asynchronous active-low reset
//   rd_addr, rd_data        : zero-latency scanner read port ({row, col} -> {red, green})
//   wr_req, wr_addr,
//   wr_data, wr_ack         : single-cell write handshake; wr_ack pulses the cycle after commit
//   clr_req, busy           : one-pulse full-board clear; busy covers the 64-cycle sweep
//   red_count, green_count  : live number of cells with the red / green bit set
module display_board_ram
   import display_board_ram_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [CELL_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [CELL_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              clr_req,
   output logic              busy,
   output logic [CNT_W-1:0]  red_count,
   output logic [CNT_W-1:0]  green_count
);

   state_t     state, state_nxt;
   cell_addr_t sweep_ptr, sweep_ptr_nxt;
   logic       ack_nxt;

   logic       arr_we;
   cell_addr_t arr_waddr;
   cell_t      arr_wdata;
   cell_t      arr_old;

   board_cell_array u_cells (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (arr_we),
      .waddr    (arr_waddr),
      .wdata    (arr_wdata),
      .old_data (arr_old),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sweep_ptr <= '0;
         wr_ack    <= 1'b0;
      end else begin
         state     <= state_nxt;
         sweep_ptr <= sweep_ptr_nxt;
         wr_ack    <= ack_nxt;
      end
   end

   // The write port is shared: the sweep owns it during CLEAR, the requester in IDLE.
   // A clear request beats a simultaneous write, which simply stays pending.
   // Gating acceptance on !wr_ack keeps a still-held request from writing twice.
   always_comb begin
      state_nxt     = state;
      sweep_ptr_nxt = sweep_ptr;
      ack_nxt       = 1'b0;
      arr_we        = 1'b0;
      arr_waddr     = wr_addr;
      arr_wdata     = wr_data;
      case (state)
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt = ST_CLEAR;
            end else if (wr_req && !wr_ack) begin
               arr_we  = 1'b1;
               ack_nxt = 1'b1;
            end
         end
         ST_CLEAR: begin
            arr_we        = 1'b1;
            arr_waddr     = sweep_ptr;
            arr_wdata     = CELL_EMPTY;
            sweep_ptr_nxt = sweep_ptr + 1'b1;   // wraps 63 -> 0 on exit
            if (sweep_ptr == LAST_CELL) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy = (state == ST_CLEAR);

   // Counts track every array write (handshake or sweep) as new-minus-old per colour,
   // so they are exact on every cycle, including mid-sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red_count   <= '0;
         green_count <= '0;
      end else if (arr_we) begin
         red_count   <= red_count   + CNT_W'(arr_wdata[SIDE_RED])   - CNT_W'(arr_old[SIDE_RED]);
         green_count <= green_count + CNT_W'(arr_wdata[SIDE_GREEN]) - CNT_W'(arr_old[SIDE_GREEN]);
      end
   end

endmodule

// File: tb/tb_display_board_ram.sv
// Self-checking bench for display_board_ram: directed scenarios plus randomized
// writes, checked against a plain array model of the board.
`timescale 1ns/1ps
module tb_display_board_ram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] rd_addr;
   logic [1:0] rd_data;
   logic       wr_req;
   logic [5:0] wr_addr;
   logic [1:0] wr_data;
   logic       wr_ack;
   logic       clr_req;
   logic       busy;
   logic [6:0] red_count;
   logic [6:0] green_count;

   always #5 clk = ~clk;

   display_board_ram dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .clr_req     (clr_req),
      .busy        (busy),
      .red_count   (red_count),
      .green_count (green_count)
   );

   int checks   = 0;
   int failures = 0;

   logic [1:0] mdl [64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Number of model cells with bit 'side' set, counting only indices >= from_idx.
   function automatic int mdl_cnt(input int side, input int from_idx);
      int n = 0;
      for (int i = from_idx; i < 64; i++) begin
         if (mdl[i][side]) n++;
      end
      return n;
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < 64; i++) mdl[i] = 2'b00;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 64; i++) begin
         rd_addr = 6'(i);
         #0.1;
         check($sformatf("%s_cell%0d", tag, i), rd_data, mdl[i]);
      end
      check({tag, "_red"},   red_count,   mdl_cnt(1, 0));
      check({tag, "_green"}, green_count, mdl_cnt(0, 0));
   endtask

   task automatic do_write(input int a, input logic [1:0] d);
      int n;
      bit got;
      @(negedge clk);
      wr_req  = 1'b1;
      wr_addr = 6'(a);
      wr_data = d;
      rd_addr = 6'(a);
      #1;
      check("rd_old", rd_data, mdl[a]);
      n = 0;
      got = 0;
      while (n < 20 && !got) begin
         @(negedge clk);
         n++;
         if (wr_ack) got = 1;
      end
      check("wr_latency", n, 1);
      wr_req = 1'b0;
      mdl[a] = d;
      #1;
      check("rd_new", rd_data, d);
      check("wr_red",   red_count,   mdl_cnt(1, 0));
      check("wr_green", green_count, mdl_cnt(0, 0));
      @(negedge clk);
      check("ack_pulse", wr_ack, 0);
   endtask

   task automatic do_clear();
      int n = 0;
      int nb = 0;
      bit mono = 1;
      logic [6:0] pr, pg;
      pr = red_count;
      pg = green_count;
      @(negedge clk);
      clr_req = 1'b1;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (n == 1)  clr_req = 1'b0;
         if (n == 10) clr_req = 1'b1;   // must be ignored mid-sweep
         if (n == 11) clr_req = 1'b0;
         if (!busy) break;
         nb++;
         // at the n-th sample cells 0..n-2 have been swept
         check("clr_red",   red_count,   mdl_cnt(1, n - 1));
         check("clr_green", green_count, mdl_cnt(0, n - 1));
         if (red_count > pr || green_count > pg) mono = 0;
         pr = red_count;
         pg = green_count;
      end
      clr_req = 1'b0;
      check("busy_cycles", nb, 64);
      check("clr_monotonic", 32'(mono), 1);
      mdl_clear();
      check_all("after_clr");
   endtask

   initial begin
      int n;
      bit ack_seen;

      rst_n   = 1'b0;
      rd_addr = '0;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      clr_req = 1'b0;
      mdl_clear();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ack",  wr_ack, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check_all("reset");

      // basic writes
      do_write(6'h09, 2'b10);
      do_write(6'h3F, 2'b01);
      check("basic_red",   red_count,   1);
      check("basic_green", green_count, 1);

      // overwrites
      do_write(6'h09, 2'b01);
      check("ovw1_red",   red_count,   0);
      check("ovw1_green", green_count, 2);
      do_write(6'h09, 2'b11);
      check("ovw2_red",   red_count,   1);
      check("ovw2_green", green_count, 2);
      do_write(6'h09, 2'b11);   // same value: counts unchanged
      check("same_red",   red_count,   1);
      check("same_green", green_count, 2);

      // fill 20 red, 5 green then sweep
      for (int i = 10; i < 30; i++) do_write(i, 2'b10);
      for (int i = 30; i < 35; i++) do_write(i, 2'b01);
      check_all("filled");
      do_clear();

      // randomized writes, then another sweep
      for (int k = 0; k < 40; k++) begin
         do_write(int'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
      end
      check_all("random");
      do_clear();

      // clear and write in the same cycle: clear wins, write completes afterwards
      @(negedge clk);
      clr_req = 1'b1;
      wr_req  = 1'b1;
      wr_addr = 6'h00;
      wr_data = 2'b10;
      n = 0;
      ack_seen = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (n == 1) clr_req = 1'b0;
         if (wr_ack) begin
            ack_seen = 1;
            break;
         end
      end
      wr_req = 1'b0;
      check("coll_ack_seen", 32'(ack_seen), 1);
      check("coll_ack_cycle", n, 66);
      mdl_clear();
      mdl[0] = 2'b10;
      @(negedge clk);
      check("coll_ack_pulse", wr_ack, 0);
      check_all("coll");

      // reset in the middle of a sweep with a stalled write pending
      for (int i = 40; i < 50; i++) do_write(i, 2'b10);
      @(negedge clk);
      clr_req = 1'b1;
      wr_req  = 1'b1;
      wr_addr = 6'h05;
      wr_data = 2'b01;
      ack_seen = 0;
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         if (k == 1) clr_req = 1'b0;
         if (wr_ack) ack_seen = 1;
      end
      check("stall_no_ack", 32'(ack_seen), 0);
      check("mid_busy", busy, 1);
      check("mid_red", red_count, mdl_cnt(1, 30));
      rst_n  = 1'b0;
      wr_req = 1'b0;
      rd_addr = 6'd45;
      #1;
      check("arst_busy",  busy, 0);
      check("arst_ack",   wr_ack, 0);
      check("arst_red",   red_count, 0);
      check("arst_green", green_count, 0);
      check("arst_cell45", rd_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ack_seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (wr_ack || busy) ack_seen = 1;
      end
      check("post_rst_quiet", 32'(ack_seen), 0);
      mdl_clear();
      check_all("post_rst");

      // board still usable after reset
      do_write(6'h2A, 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/display_board_ram.md
# display_board_ram

Dual-ported 64-cell board store that feeds the LED matrix scanner. The scanner reads it combinationally every clock, and the game logic writes single cells through a request/acknowledge handshake. The block also runs a one-command sweep that clears the whole board, and it keeps live per-colour stone counts for win and full-board detection. It sits between the game controller and the LED scanner; its read port is the scanner's `ram_rd_addr`/`ram_data` pair.

## Interface
Parameters:
- none; geometry is fixed at 8×8 cells, 2 bits per cell.

Ports:
- `clk`  in  1  system clock; the same clock the scanner uses for its line-buffer fill.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  6  scanner read address, `{row[2:0], col[2:0]}`.
- `rd_data`  out  2  cell contents; bit1 = red, bit0 = green. Combinational from `rd_addr`.
- `wr_req`  in  1  write request; held until `wr_ack`.
- `wr_addr`  in  6  cell to write; stable while `wr_req` is high.
- `wr_data`  in  2  new cell value; stable while `wr_req` is high.
- `wr_ack`  out  1  one-cycle pulse confirming the write has committed.
- `clr_req`  in  1  single-cycle pulse starting a full-board clear.
- `busy`  out  1  high while the clear sweep runs.
- `red_count`  out  7  number of cells with bit1 set, range 0..64.
- `green_count`  out  7  number of cells with bit0 set, range 0..64.

## Operation
Cell encoding:
- 00 empty, 10 red, 01 green.
- 11 is legal (both LEDs lit) and counts toward both counters.

State machine:
- **IDLE** → **CLEAR** on `clr_req`.
- **IDLE** → write accepted when `wr_req && !wr_ack`; the block stays in IDLE.
- **CLEAR** → **IDLE** after the cell at address 63 is cleared.

Write:
- On the accepting edge, `cells[wr_addr] <= wr_data` and `wr_ack` is registered high for the next cycle.
- If `wr_req` is still high while `wr_ack` is high, no second write is taken.
- Back-to-back writes are therefore accepted at most one every two cycles.

Clear:
- A 6-bit sweep pointer starts at 0.
- Each cycle the pointer writes 00 to its cell, then increments.
- 64 cycles in total; the pointer wraps from 63 back to 0 on exit.

Simultaneous events:
- `clr_req` and an acceptable `wr_req` in the same IDLE cycle: the clear wins. The write is not acked and stays pending, then completes after the clear.
- `wr_req` during CLEAR: stalled, no ack.
- `clr_req` during CLEAR: ignored; the sweep does not restart.

Counters:
- Updated on the same edge as the cell write.
- `red_count += new[1] - old[1]`, `green_count += new[0] - old[0]`, where `old` is the prior contents of the written cell.
- Rewriting a cell with the same value leaves both counts unchanged.
- The counters are exact at every cycle, including mid-clear, and end at 0/0 after a clear.
- Width is 7 bits; neither counter can overflow or underflow given the encoding.

Reads:
- Combinational and unaffected by state.
- A read of the cell being written returns the old value until the edge and the new value after it.

Reset, applied at any time including mid-clear or mid-handshake:
- All cells 00.
- `red_count`/`green_count` 0.
- `busy` 0, `wr_ack` 0.
- State IDLE, sweep pointer 0.
- Any pending request must be re-presented after reset.

## Timing
- Write latency: `wr_req` sampled high at edge N; cell and counts update at N; `wr_ack` is high during cycle N+1.
- Requester drops `wr_req` in the cycle `wr_ack` is seen.
- Clear:
  - `clr_req` at edge N.
  - `busy` high from N to N+64.
  - Cell k is cleared at edge N+1+k.
  - `busy` low after N+64.
  - The first write can be accepted at edge N+65.
- `rd_data` has zero cycle latency, so the scanner's 8-cycle line fetch sees stable data. No additional pipelining is allowed on the read path.

## Structure
- `common.vh` gains `CELL_EMPTY`, `CELL_RED`, `CELL_GREEN`, using the existing `SIDE_RED`/`SIDE_GREEN` convention for bit selection.
- Sub-module `board_cell_array` holds the 64×2 register array with asynchronous reset, one synchronous write port and one combinational read port. An extra combinational read port on `wr_addr` supplies `old` to the counter logic.
- Control FSM, sweep pointer and counters stay in `display_board_ram`.

## Test plan
- Reset, then read all 64 addresses → every `rd_data` = 00; counts 0/0; `busy` 0.
- Write 10 to addr 0x09, then write 01 to addr 0x3F:
  - each `wr_ack` pulses once, one cycle after acceptance;
  - `rd_data` at 0x09 = 10 and at 0x3F = 01;
  - `red_count` = 1, `green_count` = 1.
- Overwrite addr 0x09 with 01, then with 11:
  - after the first write, counts = 0/2;
  - after the second write, counts = 1/2.
- Fill 20 red and 5 green cells, then pulse `clr_req`:
  - `busy` stays high for exactly 64 cycles;
  - counts decrease monotonically to 0/0;
  - all cells read 00.
- Assert `clr_req` and `wr_req` (addr 0x00, data 10) in the same cycle → the clear runs first; `wr_ack` arrives at edge N+65; the final state is cell 0x00 = 10 with counts 1/0.
- Assert `rst_n` low at sweep pointer 30 with 10 red cells remaining beyond it → all outputs are at their reset values immediately, and no write occurs after release.
